cpu_multiciclo: RTL and testbench
=================================

// Module: cpu_multiciclo
// PURPOSE
//  Parametrised multi-cycle successor of the single-cycle cpu top: same 32-bit instruction format
//  (op[31:27] rd[26:22] rs1[21:17] rs2[16:12] imm[15:0] addr[9:0]), FSM-sequenced datapath.
//  Holds PC, register bank and ALU internally; instruction/data memories sit outside on sync ports.
//  Switch input and display output use valid/ready handshakes instead of a free-running input strobe.
// PARAMETERS
//  DATA_W    32  datapath/register width, legal 16..64
//  ADDR_W    10  PC and data-address width, legal 4..16
//  REG_COUNT 32  registers, legal 2..32; indices >= REG_COUNT read 0, writes ignored
// PORTS
//  clock      in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high
//  imem_addr  out  ADDR_W  = pc; imem_data valid on the following cycle
//  imem_data  in   32      instruction word
//  dmem_addr  out  ADDR_W  data address
//  dmem_wdata out  DATA_W  store data
//  dmem_we    out  1       one-cycle write strobe
//  dmem_rdata in   DATA_W  load data, valid the cycle after dmem_addr
//  in_data    in   DATA_W  switch value (zero-extended externally)
//  in_valid   in   1       in_data valid
//  in_ready   out  1       high while core waits in S_WAIT_IN
//  out_data   out  DATA_W  display value, held until next OUT
//  out_sel    out  2       display select = instr[21:20] of last OUT
//  out_valid  out  1       one-cycle pulse per OUT
//  halted     out  1       high in S_HALT
// BEHAVIOUR
//  Reset (async): pc=0, state=S_FETCH, all regs=0, all outputs 0; in-flight instr aborted, no write.
//  r0 reads 0 always; writes to r0 dropped. sext = sign-extend imm[15:0] to DATA_W.
//  FSM: S_FETCH -> S_DECODE (latch imem_data into ir, read rs1/rd/rs2) -> S_EXEC -> per opcode.
//  Opcodes (op, cycles): 0 NOP 3; 1 ADD rd=rs1+rs2 4; 2 SUB 4; 3 AND 4; 4 OR 4;
//   5 SLT rd=(signed rs1<rs2) 4; 6 ADDI rd=rs1+sext 4; 7 LI rd=sext 4;
//   8 LW rd=dmem[(rs1+sext)[ADDR_W-1:0]] 5 (EXEC addr, S_MEM wait, S_WB write);
//   9 SW dmem[(rs1+sext)]=rd 3 (dmem_we=1 in S_EXEC only);
//   10 BEQ if rd==rs1 pc=addr else pc+1, 3; 11 JMP pc=addr 3; 12 JR pc=rs1[ADDR_W-1:0] 3;
//   13 IN -> S_WAIT_IN, 14 OUT 3, 15 HALT; 16..31 treated as NOP.
//  ALU ops go S_EXEC -> S_WB (write rd) -> S_FETCH. pc=pc+1 on completion unless branch/jump.
//  Arithmetic modulo 2^DATA_W; overflow ignored. addr[9:0] zero-extended/truncated to ADDR_W.
//  PC wraps 2^ADDR_W-1 -> 0.
//  IN: S_WAIT_IN asserts in_ready; on edge with in_valid=1, rd<=in_data, pc+1, -> S_FETCH.
//   in_valid already high on entry: accepted on first S_WAIT_IN edge (IN = 3 cycles min).
//  OUT: in S_EXEC register out_data<=rd, out_sel<=instr[21:20]; out_valid=1 the next cycle only.
//  HALT: S_HALT absorbing; pc frozen, no memory strobes; leave only via reset.
//  dmem_we never asserted outside SW S_EXEC; dmem_addr don't-care when unused.
// TESTING
//  1 reset mid-LW: LI r1,5; LW r2; assert reset in S_MEM -> r2 stays 0, pc=0, outputs 0.
//  2 LI r1,7; LI r2,-3; ADD r3,r1,r2; OUT r3 -> out_data=4, one-cycle out_valid, 15 cycles total.
//  3 LI r1,0x10; SW r1,[r0+2]; LW r4,[r0+2] -> dmem_we once at addr 2 data 0x10, r4=0x10.
//  4 IN r5 with in_valid low 20 cycles, then 0x2A -> in_ready high 20+ cycles, r5=0x2A.
//  5 BEQ r0,r0->addr 8; at 8 HALT -> pc=8, halted=1, no further imem_addr change.
//  6 ADDI r1,r0,-1 with DATA_W=16; LI r0,9 -> r1=0xFFFF, r0 reads 0.

Source files
------------

// File: rtl/cpu_multiciclo.sv
// Multi-cycle accumulator-free RISC core: FSM-sequenced datapath with an
// internal PC, register bank and ALU. Instruction and data memories are
// external synchronous ports (data valid the cycle after the address).
// The switch input and the display output use valid/ready handshakes.
module cpu_multiciclo #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int REG_COUNT = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    output logic              halted
);

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_SLT  = 5'd5;
    localparam logic [4:0] OP_ADDI = 5'd6;
    localparam logic [4:0] OP_LI   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SW   = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_JMP  = 5'd11;
    localparam logic [4:0] OP_JR   = 5'd12;
    localparam logic [4:0] OP_IN   = 5'd13;
    localparam logic [4:0] OP_OUT  = 5'd14;
    localparam logic [4:0] OP_HALT = 5'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_WAIT_IN,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] rs1_q, rs1_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;
    logic [DATA_W-1:0] rd_val_q, rd_val_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;

    // Register bank read view and write port
    logic [DATA_W-1:0] reg_rd [32];
    logic              wr_en;
    logic [4:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;

    logic [4:0]        op;
    logic [DATA_W-1:0] sext;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jmp_tgt;

    assign op      = ir_q[31:27];
    assign sext    = DATA_W'($signed(ir_q[15:0]));
    assign pc_inc  = pc_q + ADDR_W'(1);
    // 10-bit absolute target, zero-extended or truncated to the PC width
    assign jmp_tgt = ADDR_W'(ir_q[9:0]);

    // r0 and indices beyond the bank read as zero and have no storage;
    // every other register is written only from the single write port.
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
        if (gi == 0 || gi >= REG_COUNT) begin : g_zero
            assign reg_rd[gi] = '0;
        end else begin : g_live
            logic [DATA_W-1:0] r_q;
            // Register storage, cleared by reset
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (wr_en && (wr_idx == 5'(gi))) begin
                    r_q <= wr_data;
                end
            end
            assign reg_rd[gi] = r_q;
        end
    end

    // Next-state, datapath and strobe decode for the instruction sequencer
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_val_d    = rd_val_q;
        res_d       = res_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = ir_q[26:22];
        wr_data     = res_q;
        dmem_we     = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d     = imem_data;
                rs1_d    = reg_rd[imem_data[21:17]];
                rs2_d    = reg_rd[imem_data[16:12]];
                rd_val_d = reg_rd[imem_data[26:22]];
                // IN skips EXEC so an already-valid input completes in 3 cycles
                state_d  = (imem_data[31:27] == OP_IN) ? S_WAIT_IN : S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD: begin
                        res_d   = rs1_q + rs2_q;
                        state_d = S_WB;
                    end
                    OP_SUB: begin
                        res_d   = rs1_q - rs2_q;
                        state_d = S_WB;
                    end
                    OP_AND: begin
                        res_d   = rs1_q & rs2_q;
                        state_d = S_WB;
                    end
                    OP_OR: begin
                        res_d   = rs1_q | rs2_q;
                        state_d = S_WB;
                    end
                    OP_SLT: begin
                        res_d   = ($signed(rs1_q) < $signed(rs2_q)) ? DATA_W'(1) : '0;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        res_d   = rs1_q + sext;
                        state_d = S_WB;
                    end
                    OP_LI: begin
                        res_d   = sext;
                        state_d = S_WB;
                    end
                    OP_LW: begin
                        state_d = S_MEM;
                    end
                    OP_SW: begin
                        dmem_we = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                    OP_BEQ: begin
                        pc_d    = (rd_val_q == rs1_q) ? jmp_tgt : pc_inc;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = jmp_tgt;
                        state_d = S_FETCH;
                    end
                    OP_JR: begin
                        pc_d    = rs1_q[ADDR_W-1:0];
                        state_d = S_FETCH;
                    end
                    OP_OUT: begin
                        out_data_d  = rd_val_q;
                        out_sel_d   = ir_q[21:20];
                        out_valid_d = 1'b1;
                        pc_d        = pc_inc;
                        state_d     = S_FETCH;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                // Load data arrives one cycle after the address; capture it here
                res_d   = dmem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                wr_en   = 1'b1;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = in_data;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Sequencer and datapath registers; reset aborts any in-flight instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_val_q    <= '0;
            res_q       <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_val_q    <= rd_val_d;
            res_q       <= res_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = rs1_q[ADDR_W-1:0] + sext[ADDR_W-1:0];
    assign dmem_wdata = rd_val_q;
    assign in_ready   = (state_q == S_WAIT_IN);
    assign halted     = (state_q == S_HALT);
    assign out_data   = out_data_q;
    assign out_sel    = out_sel_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_cpu_multiciclo.sv
// Testbench for cpu_multiciclo: small programs loaded into a behavioural
// instruction memory; display outputs and data-memory writes are checked
// against scoreboard queues filled when each program is set up.
module tb_cpu_multiciclo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst16 = 1'b1;
    always #5 clk = ~clk;

    // Main instance: default parameters
    logic [9:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        halted;

    cpu_multiciclo #(.DATA_W(32), .ADDR_W(10), .REG_COUNT(32)) dut (
        .clock(clk), .reset(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .halted(halted)
    );

    // Narrow instance: 16-bit data, 6-bit PC, 4 registers
    logic [5:0]  imem16_addr;
    logic [31:0] imem16_data = '0;
    logic [5:0]  dmem16_addr;
    logic [15:0] dmem16_wdata;
    logic        dmem16_we;
    logic [15:0] dmem16_rdata = '0;
    logic [15:0] in16_data = '0;
    logic        in16_valid = 1'b0;
    logic        in16_ready;
    logic [15:0] out16_data;
    logic [1:0]  out16_sel;
    logic        out16_valid;
    logic        halted16;

    cpu_multiciclo #(.DATA_W(16), .ADDR_W(6), .REG_COUNT(4)) dut16 (
        .clock(clk), .reset(rst16),
        .imem_addr(imem16_addr), .imem_data(imem16_data),
        .dmem_addr(dmem16_addr), .dmem_wdata(dmem16_wdata), .dmem_we(dmem16_we),
        .dmem_rdata(dmem16_rdata),
        .in_data(in16_data), .in_valid(in16_valid), .in_ready(in16_ready),
        .out_data(out16_data), .out_sel(out16_sel), .out_valid(out16_valid),
        .halted(halted16)
    );

    logic [31:0] imem   [1024];
    logic [31:0] dmem   [1024];
    logic [31:0] imem16 [64];

    always @(posedge clk) begin
        imem_data <= imem[imem_addr];
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        dmem_rdata <= dmem[dmem_addr];
        imem16_data <= imem16[imem16_addr];
    end

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
    } outexp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wexp_t;

    outexp_t     exp_q   [$];
    wexp_t       wq      [$];
    logic [15:0] exp16_q [$];
    logic [31:0] prog    [$];

    int checks = 0;
    int failures = 0;
    int wcount = 0;
    logic prev_ov = 1'b0;

    localparam logic [31:0] HALT_W = {5'd15, 27'd0};

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 12'h000};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, 1'b0, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [9:0] addr);
        return {op, rd, rs1, 7'd0, addr};
    endfunction

    function automatic logic [31:0] enc_out(input logic [4:0] rd, input logic [1:0] sel);
        return {5'd14, rd, sel, 3'b000, 17'd0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Display monitor: every out_valid pulse pops one expected value
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got data=%0h sel=%0d expected no output", out_data, out_sel);
            end else begin
                outexp_t e;
                e = exp_q.pop_front();
                if (out_data !== e.data || out_sel !== e.sel) begin
                    failures++;
                    $display("FAIL out_value: got data=%0h sel=%0d expected data=%0h sel=%0d",
                             out_data, out_sel, e.data, e.sel);
                end
            end
            if (prev_ov) begin
                failures++;
                $display("FAIL out_pulse: got out_valid high 2 cycles expected 1");
            end
        end
        prev_ov = out_valid;
    end

    // Data-memory write monitor
    always @(negedge clk) begin
        if (dmem_we) begin
            wcount++;
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL we_unexpected: got write addr=%0h data=%0h expected none", dmem_addr, dmem_wdata);
            end else begin
                wexp_t w;
                w = wq.pop_front();
                if (dmem_addr !== w.addr || dmem_wdata !== w.data) begin
                    failures++;
                    $display("FAIL we_value: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             dmem_addr, dmem_wdata, w.addr, w.data);
                end
            end
        end
    end

    // Narrow-instance display monitor
    always @(negedge clk) begin
        if (out16_valid) begin
            checks++;
            if (exp16_q.size() == 0) begin
                failures++;
                $display("FAIL out16_unexpected: got %0h expected no output", out16_data);
            end else begin
                logic [15:0] e16;
                e16 = exp16_q.pop_front();
                if (out16_data !== e16) begin
                    failures++;
                    $display("FAIL out16_value: got %0h expected %0h", out16_data, e16);
                end
            end
        end
    end

    task automatic load_prog();
        for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, halted, 1);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_outq"}, exp_q.size(), 0);
        chk({name, "_wq"}, wq.size(), 0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{op: 5'd1,  a: 16'd7,     b: 16'hFFFD, exp: 32'd4};
        vecs[1]  = '{op: 5'd1,  a: 16'h7FFF,  b: 16'h7FFF, exp: 32'h0000FFFE};
        vecs[2]  = '{op: 5'd1,  a: 16'hFFFF,  b: 16'd1,    exp: 32'h00000000};
        vecs[3]  = '{op: 5'd2,  a: 16'd5,     b: 16'd9,    exp: 32'hFFFFFFFC};
        vecs[4]  = '{op: 5'd3,  a: 16'h0F0F,  b: 16'h00FF, exp: 32'h0000000F};
        vecs[5]  = '{op: 5'd4,  a: 16'h0F00,  b: 16'h00F0, exp: 32'h00000FF0};
        vecs[6]  = '{op: 5'd5,  a: 16'hFFFF,  b: 16'd1,    exp: 32'd1};
        vecs[7]  = '{op: 5'd5,  a: 16'd3,     b: 16'hFFFE, exp: 32'd0};
        vecs[8]  = '{op: 5'd6,  a: 16'h7FFF,  b: 16'd1,    exp: 32'h00008000};
        vecs[9]  = '{op: 5'd6,  a: 16'd0,     b: 16'hFFFF, exp: 32'hFFFFFFFF};
        vecs[10] = '{op: 5'd7,  a: 16'd0,     b: 16'h8000, exp: 32'hFFFF8000};
        vecs[11] = '{op: 5'd0,  a: 16'd1,     b: 16'd2,    exp: 32'h0000005A};
        vecs[12] = '{op: 5'd20, a: 16'd1,     b: 16'd2,    exp: 32'h0000005A};

        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        for (int i = 0; i < 64; i++) imem16[i] = HALT_W;
        prog.delete();
        load_prog();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);

        // ALU vector table
        for (int i = 0; i < 13; i++) begin
            logic [31:0] ins;
            if (vecs[i].op == 5'd6)      ins = enc_i(5'd6, 5'd3, 5'd1, vecs[i].b);
            else if (vecs[i].op == 5'd7) ins = enc_i(5'd7, 5'd3, 5'd0, vecs[i].b);
            else                         ins = enc_r(vecs[i].op, 5'd3, 5'd1, 5'd2);
            prog.delete();
            prog.push_back(enc_i(5'd7, 5'd1, 5'd0, vecs[i].a));
            prog.push_back(enc_i(5'd7, 5'd2, 5'd0, vecs[i].b));
            prog.push_back(enc_i(5'd7, 5'd3, 5'd0, 16'h005A));
            prog.push_back(ins);
            prog.push_back(enc_out(5'd3, 2'(i)));
            prog.push_back(HALT_W);
            exp_q.push_back('{data: vecs[i].exp, sel: 2'(i)});
            load_prog();
            do_reset();
            wait_halt("vec_halt", 100);
            chk("vec_pc", imem_addr, 5);
            chk_drained("vec");
            $display("vec %0d op=%0d a=%0h b=%0h exp=%0h", i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // LI, LI, ADD, OUT: 15 cycles to the output pulse
        begin
            int n;
            logic seen;
            prog.delete();
            prog.push_back(enc_i(5'd7, 5'd1, 5'd0, 16'd7));
            prog.push_back(enc_i(5'd7, 5'd2, 5'd0, 16'hFFFD));
            prog.push_back(enc_r(5'd1, 5'd3, 5'd1, 5'd2));
            prog.push_back(enc_out(5'd3, 2'd2));
            prog.push_back(HALT_W);
            exp_q.push_back('{data: 32'd4, sel: 2'd2});
            load_prog();
            do_reset();
            n = 0;
            seen = 1'b0;
            while (!seen && n < 40) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                seen = out_valid;
            end
            chk("t2_cycles", n, 15);
            @(negedge clk);
            chk("t2_pulse_end", out_valid, 0);
            chk("t2_data_held", out_data, 4);
            wait_halt("t2_halt", 50);
            chk_drained("t2");
            $display("t2 add/out cycles=%0d", n);
        end

        // SW then LW to the same address
        begin
            prog.delete();
            prog.push_back(enc_i(5'd7, 5'd1, 5'd0, 16'h0010));
            prog.push_back(enc_i(5'd9, 5'd1, 5'd0, 16'd2));
            prog.push_back(enc_i(5'd8, 5'd4, 5'd0, 16'd2));
            prog.push_back(enc_out(5'd4, 2'd1));
            prog.push_back(HALT_W);
            wcount = 0;
            wq.push_back('{addr: 10'd2, data: 32'h10});
            exp_q.push_back('{data: 32'h10, sel: 2'd1});
            load_prog();
            do_reset();
            wait_halt("t3_halt", 100);
            chk("t3_we_count", wcount, 1);
            chk("t3_mem", dmem[2], 32'h10);
            chk_drained("t3");
            $display("t3 sw/lw writes=%0d", wcount);
        end

        // Reset asserted while a load sits in S_MEM
        begin
            dmem[5] = 32'h55;
            prog.delete();
            prog.push_back(enc_i(5'd7, 5'd1, 5'd0, 16'd5));
            prog.push_back(enc_i(5'd8, 5'd2, 5'd1, 16'd0));
            prog.push_back(enc_out(5'd2, 2'd0));
            prog.push_back(HALT_W);
            load_prog();
            do_reset();
            repeat (7) @(posedge clk);
            @(negedge clk);
            chk("t1_lw_addr", dmem_addr, 5);
            rst = 1'b1;
            #1;
            chk("t1_rst_pc", imem_addr, 0);
            chk("t1_rst_daddr", dmem_addr, 0);
            chk("t1_rst_we", dmem_we, 0);
            chk("t1_rst_out_data", out_data, 0);
            chk("t1_rst_out_valid", out_valid, 0);
            chk("t1_rst_halted", halted, 0);
            prog.delete();
            prog.push_back(enc_out(5'd2, 2'd3));
            prog.push_back(HALT_W);
            exp_q.push_back('{data: 32'd0, sel: 2'd3});
            load_prog();
            @(negedge clk);
            rst = 1'b0;
            wait_halt("t1_halt", 50);
            chk("t1_pc", imem_addr, 1);
            chk_drained("t1");
            $display("t1 reset mid-load done");
        end

        // IN with a long wait for valid
        begin
            int n;
            int hi;
            in_valid = 1'b0;
            prog.delete();
            prog.push_back(enc_i(5'd13, 5'd5, 5'd0, 16'd0));
            prog.push_back(enc_out(5'd5, 2'd0));
            prog.push_back(HALT_W);
            exp_q.push_back('{data: 32'h2A, sel: 2'd0});
            load_prog();
            do_reset();
            n = 0;
            while (!in_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("t4_ready", in_ready, 1);
            hi = 0;
            repeat (20) begin
                @(negedge clk);
                if (in_ready) hi++;
            end
            chk("t4_ready_cycles", hi, 20);
            chk("t4_pc_waiting", imem_addr, 0);
            in_data = 32'h2A;
            in_valid = 1'b1;
            @(negedge clk);
            chk("t4_ready_drop", in_ready, 0);
            in_valid = 1'b0;
            wait_halt("t4_halt", 50);
            chk_drained("t4");
            $display("t4 in after wait ready_cycles=%0d", hi);
        end

        // IN with valid already high: 3 cycles
        begin
            in_data = 32'h33;
            in_valid = 1'b1;
            prog.delete();
            prog.push_back(enc_i(5'd13, 5'd6, 5'd0, 16'd0));
            prog.push_back(enc_out(5'd6, 2'd1));
            prog.push_back(HALT_W);
            exp_q.push_back('{data: 32'h33, sel: 2'd1});
            load_prog();
            do_reset();
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("t4b_pc", imem_addr, 1);
            in_valid = 1'b0;
            wait_halt("t4b_halt", 50);
            chk_drained("t4b");
            $display("t4b in immediate");
        end

        // BEQ taken to a HALT; PC frozen afterwards
        begin
            prog.delete();
            prog.push_back(enc_j(5'd10, 5'd0, 5'd0, 10'd8));
            prog.push_back(enc_out(5'd0, 2'd0));
            wcount = 0;
            load_prog();
            do_reset();
            wait_halt("t5_halt", 50);
            chk("t5_pc", imem_addr, 8);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("t5_pc_frozen", imem_addr, 8);
            end
            chk("t5_halted", halted, 1);
            chk("t5_no_write", wcount, 0);
            chk_drained("t5");
            $display("t5 beq taken halted pc=%0d", imem_addr);
        end

        // BEQ not taken, JR, JMP
        begin
            prog.delete();
            prog.push_back(enc_i(5'd7, 5'd1, 5'd0, 16'd1));   // 0
            prog.push_back(enc_j(5'd10, 5'd1, 5'd0, 10'd8));  // 1
            prog.push_back(enc_i(5'd7, 5'd2, 5'd0, 16'd6));   // 2
            prog.push_back(enc_r(5'd12, 5'd0, 5'd2, 5'd0));   // 3
            prog.push_back(enc_out(5'd1, 2'd3));              // 4
            prog.push_back(HALT_W);                           // 5
            prog.push_back(enc_j(5'd11, 5'd0, 5'd0, 10'd10)); // 6
            prog.push_back(HALT_W);                           // 7
            prog.push_back(enc_out(5'd2, 2'd1));              // 8
            prog.push_back(HALT_W);                           // 9
            prog.push_back(enc_out(5'd1, 2'd2));              // 10
            prog.push_back(HALT_W);                           // 11
            exp_q.push_back('{data: 32'd1, sel: 2'd2});
            load_prog();
            do_reset();
            wait_halt("t5b_halt", 100);
            chk("t5b_pc", imem_addr, 11);
            chk_drained("t5b");
            $display("t5b beq not taken, jr, jmp");
        end

        // Narrow instance: 16-bit wrap, r0 hard zero, registers past the bank
        begin
            int n;
            imem16[0] = enc_i(5'd6, 5'd1, 5'd0, 16'hFFFF);
            imem16[1] = enc_i(5'd7, 5'd0, 5'd0, 16'd9);
            imem16[2] = enc_i(5'd7, 5'd5, 5'd0, 16'd7);
            imem16[3] = enc_out(5'd1, 2'd0);
            imem16[4] = enc_out(5'd0, 2'd1);
            imem16[5] = enc_out(5'd5, 2'd2);
            imem16[6] = enc_r(5'd1, 5'd2, 5'd1, 5'd1);
            imem16[7] = enc_out(5'd2, 2'd3);
            imem16[8] = HALT_W;
            exp16_q.push_back(16'hFFFF);
            exp16_q.push_back(16'h0000);
            exp16_q.push_back(16'h0000);
            exp16_q.push_back(16'hFFFE);
            @(negedge clk);
            rst16 = 1'b0;
            n = 0;
            while (!halted16 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("t6_halt", halted16, 1);
            chk("t6_pc", imem16_addr, 8);
            chk("t6_outq", exp16_q.size(), 0);
            $display("t6 narrow instance cycles=%0d", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
